// File: rtl/tx_arbiter.sv
// Two-channel arbiter feeding a byte-wide UART transmitter.
// Each slave channel owns a one-entry word buffer; words are sent LSB byte first.
module tx_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1048575
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_s1,
  input  logic              valid_s2,
  input  logic [DATA_W-1:0] data_s1,
  input  logic [DATA_W-1:0] data_s2,
  input  logic [ADDR_W-1:0] addr_s1,
  input  logic [ADDR_W-1:0] addr_s2,
  output logic              pready_s1,
  output logic              pready_s2,
  output logic              valid_tx,
  output logic [7:0]        data_tx,
  input  logic              tx_busy,
  input  logic              done,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        grant,
  output logic [1:0]        err_ovf,
  output logic              err_tmo
);

  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_RDY  = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4,
    RELEASE   = 3'd5
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [1:0]          full_r;
  logic [DATA_W-1:0]   buf_data1_r;
  logic [DATA_W-1:0]   buf_data2_r;
  logic [ADDR_W-1:0]   buf_addr1_r;
  logic [ADDR_W-1:0]   buf_addr2_r;
  logic                win_r;       // 0 = channel 1, 1 = channel 2
  logic                rr_r;        // 1 = channel 2 preferred on contention
  logic [DATA_W-1:0]   word_r;
  logic [BW-1:0]       byte_cnt_r;
  logic [TW-1:0]       tmo_cnt_r;
  logic                valid_tx_r;
  logic [7:0]          data_tx_r;
  logic [ADDR_W-1:0]   addr_out_r;
  logic [1:0]          grant_r;
  logic [1:0]          err_ovf_r;
  logic                err_tmo_r;
  logic                pick_s;
  logic                tmo_hit_s;
  logic [1:0]          rel_s;

  // Next-state decode plus arbitration and release strobes.
  always_comb begin
    next_state_s = state_r;
    pick_s       = 1'b0;
    tmo_hit_s    = (tmo_cnt_r == TMO_LAST);
    rel_s        = 2'b00;
    if (full_r == 2'b11) begin
      pick_s = rr_r;
    end else if (full_r[1]) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (state_r == RELEASE) begin
      rel_s = win_r ? 2'b10 : 2'b01;
    end else begin
      rel_s = 2'b00;
    end
    case (state_r)
      IDLE: begin
        if (full_r != 2'b00) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: next_state_s = WAIT_RDY;
      WAIT_RDY: begin
        if (!tx_busy) begin
          next_state_s = SEND;
        end else begin
          next_state_s = WAIT_RDY;
        end
      end
      SEND: next_state_s = WAIT_DONE;
      WAIT_DONE: begin
        if (done) begin
          next_state_s = (byte_cnt_r == LAST_BYTE) ? RELEASE : WAIT_RDY;
        end else if (tmo_hit_s) begin
          next_state_s = RELEASE;
        end else begin
          next_state_s = WAIT_DONE;
        end
      end
      RELEASE: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Holding buffers; a request hitting a full buffer is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r      <= 2'b00;
      buf_data1_r <= '0;
      buf_data2_r <= '0;
      buf_addr1_r <= '0;
      buf_addr2_r <= '0;
      err_ovf_r   <= 2'b00;
    end else begin
      if (valid_s1 && !full_r[0]) begin
        buf_data1_r <= data_s1;
        buf_addr1_r <= addr_s1;
      end
      if (valid_s2 && !full_r[1]) begin
        buf_data2_r <= data_s2;
        buf_addr2_r <= addr_s2;
      end
      if (valid_s1 && full_r[0]) begin
        err_ovf_r[0] <= 1'b1;
      end
      if (valid_s2 && full_r[1]) begin
        err_ovf_r[1] <= 1'b1;
      end
      full_r[0] <= full_r[0] ? !rel_s[0] : valid_s1;
      full_r[1] <= full_r[1] ? !rel_s[1] : valid_s2;
    end
  end

  // Transfer datapath: word shifter, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_r      <= 1'b0;
      rr_r       <= 1'b0;
      word_r     <= '0;
      byte_cnt_r <= '0;
      tmo_cnt_r  <= '0;
      valid_tx_r <= 1'b0;
      data_tx_r  <= 8'h00;
      addr_out_r <= '0;
      grant_r    <= 2'b00;
      err_tmo_r  <= 1'b0;
    end else begin
      valid_tx_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (full_r != 2'b00) begin
            win_r <= pick_s;
          end
        end
        LOAD: begin
          word_r     <= win_r ? buf_data2_r : buf_data1_r;
          addr_out_r <= win_r ? buf_addr2_r : buf_addr1_r;
          grant_r    <= win_r ? 2'b10 : 2'b01;
          byte_cnt_r <= '0;
        end
        WAIT_RDY: begin
          // valid_tx is raised on entry to SEND so it is high for exactly that cycle
          if (!tx_busy) begin
            valid_tx_r <= 1'b1;
            data_tx_r  <= word_r[7:0];
          end
        end
        SEND: begin
          tmo_cnt_r <= '0;
        end
        WAIT_DONE: begin
          if (done) begin
            byte_cnt_r <= byte_cnt_r + BW'(1);
            word_r     <= word_r >> 4'd8;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
            if (tmo_hit_s) begin
              err_tmo_r <= 1'b1;
            end
          end
        end
        RELEASE: begin
          rr_r    <= ~win_r;
          grant_r <= 2'b00;
        end
        default: begin
          grant_r <= 2'b00;
        end
      endcase
    end
  end

  assign pready_s1 = ~full_r[0];
  assign pready_s2 = ~full_r[1];
  assign valid_tx  = valid_tx_r;
  assign data_tx   = data_tx_r;
  assign addr_out  = addr_out_r;
  assign grant     = grant_r;
  assign err_ovf   = err_ovf_r;
  assign err_tmo   = err_tmo_r;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed vector table, multi-cycle corner
// sequences, and a randomized run scored against per-channel word queues.
module tb_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_s1 = 1'b0;
  logic        valid_s2 = 1'b0;
  logic [31:0] data_s1 = 32'h0;
  logic [31:0] data_s2 = 32'h0;
  logic [31:0] addr_s1 = 32'h0;
  logic [31:0] addr_s2 = 32'h0;
  logic        pready_s1, pready_s2, valid_tx, err_tmo;
  logic [7:0]  data_tx;
  logic [31:0] addr_out;
  logic [1:0]  grant, err_ovf;
  logic        tx_busy;
  logic        done;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  done_en = 1'b1;
  int  done_dly = 3;
  bit  rnd_mode = 1'b0;
  bit  busy_force = 1'b0;
  bit  rnd_busy = 1'b0;

  logic [7:0]  cap_b[$];
  logic [1:0]  cap_g[$];
  logic [31:0] cap_a[$];
  int          cap_c[$];
  logic [7:0]  exp_b[$];
  logic [1:0]  exp_g[$];
  logic [31:0] exp_a[$];

  assign tx_busy = rnd_mode ? rnd_busy : busy_force;

  tx_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst),
    .valid_s1(valid_s1), .valid_s2(valid_s2),
    .data_s1(data_s1), .data_s2(data_s2),
    .addr_s1(addr_s1), .addr_s2(addr_s2),
    .pready_s1(pready_s1), .pready_s2(pready_s2),
    .valid_tx(valid_tx), .data_tx(data_tx),
    .tx_busy(tx_busy), .done(done),
    .addr_out(addr_out), .grant(grant),
    .err_ovf(err_ovf), .err_tmo(err_tmo)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Byte monitor.
  initial forever begin
    @(negedge clk);
    if (valid_tx === 1'b1) begin
      cap_b.push_back(data_tx);
      cap_g.push_back(grant);
      cap_a.push_back(addr_out);
      cap_c.push_back(cyc);
    end
  end

  // Transmitter model: returns done after a delay; random busy and stray done in random mode.
  initial begin
    int cnt;
    cnt = 0;
    done = 1'b0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) done = 1'b1;
      end
      if (valid_tx === 1'b1 && done_en) cnt = rnd_mode ? int'($urandom_range(6, 1)) : done_dly;
      if (rnd_mode) begin
        rnd_busy = ($urandom_range(3, 0) == 0);
        if (cnt == 0 && !done && $urandom_range(9, 0) == 0) done = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_b.delete(); cap_g.delete(); cap_a.delete(); cap_c.delete();
    exp_b.delete(); exp_g.delete(); exp_a.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_cap();
  endtask

  // Requests are high for the current cycle only.
  task automatic drive(input bit c1, input bit c2, input logic [31:0] d1, input logic [31:0] a1,
                       input logic [31:0] d2, input logic [31:0] a2);
    valid_s1 = c1; data_s1 = d1; addr_s1 = a1;
    valid_s2 = c2; data_s2 = d2; addr_s2 = a2;
    step();
    valid_s1 = 1'b0;
    valid_s2 = 1'b0;
  endtask

  task automatic wait_bytes(input string name, input int n, input int limit);
    for (int i = 0; i < limit && cap_b.size() < n; i++) step();
    chk({name, "_wait"}, 32'(cap_b.size() >= n), 32'd1);
  endtask

  function automatic void push_word(input logic [31:0] d, input logic [1:0] g, input logic [31:0] a);
    for (int k = 0; k < 4; k++) begin
      exp_b.push_back(d[8*k +: 8]);
      exp_g.push_back(g);
      exp_a.push_back(a);
    end
  endfunction

  task automatic check_stream(input string name);
    chk({name, "_len"}, 32'(cap_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i), 32'(cap_b[i]), 32'(exp_b[i]));
      chk($sformatf("%s_grant%0d", name, i), 32'(cap_g[i]), 32'(exp_g[i]));
      chk($sformatf("%s_addr%0d", name, i), cap_a[i], exp_a[i]);
    end
    clear_cap();
  endtask

  typedef struct {
    bit          ch2;
    logic [31:0] data;
    logic [31:0] addr;
    int          dly;
    logic [31:0] seq;   // expected bytes, first-sent in bits 31:24
    logic [1:0]  g;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   n0, b0, s0;
    logic [31:0] rq_d1[$], rq_a1[$], rq_d2[$], rq_a2[$];
    logic [1:0]  ovf_exp;

    tbl[0] = '{1'b0, 32'hA1B2C3D4, 32'h0000_0010, 20, 32'hD4C3B2A1, 2'b01};
    tbl[1] = '{1'b1, 32'h1122_3344, 32'h0000_0200, 3,  32'h4433_2211, 2'b10};
    tbl[2] = '{1'b0, 32'hFF00_FF00, 32'hFFFF_FFFC, 1,  32'h00FF_00FF, 2'b01};
    tbl[3] = '{1'b1, 32'h8001_7E55, 32'hDEAD_BEEF, 7,  32'h557E_0180, 2'b10};

    // Reset values
    step();
    do_reset();
    chk("rst_pready", {30'd0, pready_s2, pready_s1}, 32'd3);
    chk("rst_valid_tx", 32'(valid_tx), 32'd0);
    chk("rst_data_tx", 32'(data_tx), 32'd0);
    chk("rst_addr_out", addr_out, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_err_ovf", 32'(err_ovf), 32'd0);
    chk("rst_err_tmo", 32'(err_tmo), 32'd0);

    // Single-word vectors
    for (int i = 0; i < 4; i++) begin
      clear_cap();
      done_dly = tbl[i].dly;
      n0 = cyc;
      drive(!tbl[i].ch2, tbl[i].ch2, tbl[i].data, tbl[i].addr, tbl[i].data, tbl[i].addr);
      wait_bytes($sformatf("vec%0d", i), 4, 300);
      for (int k = 0; k < 4; k++) begin
        if (cap_b.size() > k) begin
          chk($sformatf("vec%0d_byte%0d", i, k), 32'(cap_b[k]), 32'(tbl[i].seq[31-8*k -: 8]));
          chk($sformatf("vec%0d_grant%0d", i, k), 32'(cap_g[k]), 32'(tbl[i].g));
          chk($sformatf("vec%0d_addr%0d", i, k), cap_a[k], tbl[i].addr);
        end
      end
      if (cap_c.size() > 0) chk($sformatf("vec%0d_latency", i), 32'(cap_c[0] - n0), 32'd4);
      repeat (tbl[i].dly + 4) step();
      chk($sformatf("vec%0d_pready", i), {30'd0, pready_s2, pready_s1}, 32'd3);
      chk($sformatf("vec%0d_grant_idle", i), 32'(grant), 32'd0);
      chk($sformatf("vec%0d_valid_idle", i), 32'(valid_tx), 32'd0);
      chk($sformatf("vec%0d_data_hold", i), 32'(data_tx), 32'(tbl[i].seq[7:0]));
      chk($sformatf("vec%0d_addr_hold", i), addr_out, tbl[i].addr);
    end

    // Simultaneous requests and round-robin
    do_reset();
    done_dly = 2;
    drive(1'b1, 1'b1, 32'h0403_0201, 32'h100, 32'h0807_0605, 32'h200);
    wait_bytes("pair1", 8, 400);
    push_word(32'h0403_0201, 2'b01, 32'h100);
    push_word(32'h0807_0605, 2'b10, 32'h200);
    repeat (10) step();
    check_stream("pair1");
    drive(1'b1, 1'b0, 32'h0C0B_0A09, 32'h104, 32'h0, 32'h0);
    wait_bytes("single", 4, 200);
    repeat (10) step();
    push_word(32'h0C0B_0A09, 2'b01, 32'h104);
    check_stream("single");
    drive(1'b1, 1'b1, 32'h1413_1211, 32'h108, 32'h1817_1615, 32'h208);
    wait_bytes("pair2", 8, 400);
    repeat (10) step();
    push_word(32'h1817_1615, 2'b10, 32'h208);
    push_word(32'h1413_1211, 2'b01, 32'h108);
    check_stream("pair2");

    // Overflow on channel 2
    do_reset();
    done_dly = 10;
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h2A2B_2C2D, 32'h300);
    step();
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'hDEAD_0000, 32'h301);
    wait_bytes("ovf2", 4, 300);
    repeat (40) step();
    chk("ovf2_flag", 32'(err_ovf), 32'd2);
    push_word(32'h2A2B_2C2D, 2'b10, 32'h300);
    check_stream("ovf2");

    // Request on channel 1 during its own RELEASE cycle
    done_dly = 5;
    drive(1'b1, 1'b0, 32'h3132_3334, 32'h400, 32'h0, 32'h0);
    wait_bytes("relovf", 4, 300);
    repeat (6) step();
    chk("relovf_pready", 32'(pready_s1), 32'd0);
    drive(1'b1, 1'b0, 32'h9999_9999, 32'h401, 32'h0, 32'h0);
    repeat (30) step();
    chk("relovf_flag", 32'(err_ovf), 32'd3);
    push_word(32'h3132_3334, 2'b01, 32'h400);
    check_stream("relovf");

    // Timeout with done never returned
    do_reset();
    done_en = 1'b0;
    drive(1'b1, 1'b0, 32'h55AA_55AA, 32'h500, 32'h0, 32'h0);
    wait_bytes("tmo", 1, 100);
    repeat (50) step();
    chk("tmo_before", 32'(err_tmo), 32'd0);
    step();
    chk("tmo_set", 32'(err_tmo), 32'd1);
    step();
    chk("tmo_grant", 32'(grant), 32'd0);
    chk("tmo_pready", 32'(pready_s1), 32'd1);
    repeat (20) step();
    chk("tmo_one_byte", 32'(cap_b.size()), 32'd1);
    chk("tmo_sticky", 32'(err_tmo), 32'd1);
    done_en = 1'b1;

    // Busy hold, then reset after the second byte
    do_reset();
    done_dly = 3;
    busy_force = 1'b1;
    drive(1'b1, 1'b0, 32'hCAFE_F00D, 32'h600, 32'h0, 32'h0);
    repeat (29) step();
    chk("busy_no_tx", 32'(cap_b.size()), 32'd0);
    b0 = cyc;
    busy_force = 1'b0;
    wait_bytes("busy_first", 1, 50);
    if (cap_c.size() > 0) chk("busy_release_lat", 32'(cap_c[0] - b0), 32'd1);
    wait_bytes("busy_second", 2, 50);
    rst = 1'b1;
    step();
    chk("midrst_valid_tx", 32'(valid_tx), 32'd0);
    chk("midrst_data_tx", 32'(data_tx), 32'd0);
    chk("midrst_addr_out", addr_out, 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_pready", {30'd0, pready_s2, pready_s1}, 32'd3);
    chk("midrst_errs", {29'd0, err_tmo, err_ovf}, 32'd0);
    rst = 1'b0;
    repeat (40) step();
    chk("midrst_no_more", 32'(cap_b.size()), 32'd2);

    // Randomized traffic against per-channel word queues
    do_reset();
    rnd_mode = 1'b1;
    ovf_exp = 2'b00;
    for (int t = 0; t < 3000; t++) begin
      logic [31:0] d, a;
      valid_s1 = 1'b0;
      valid_s2 = 1'b0;
      if ($urandom_range(7, 0) == 0) begin
        d = $urandom; a = $urandom;
        if (pready_s1) begin
          rq_d1.push_back(d); rq_a1.push_back(a);
          valid_s1 = 1'b1; data_s1 = d; addr_s1 = a;
        end else if ($urandom_range(3, 0) == 0) begin
          ovf_exp[0] = 1'b1;
          valid_s1 = 1'b1; data_s1 = d; addr_s1 = a;
        end
      end
      if ($urandom_range(7, 0) == 0) begin
        d = $urandom; a = $urandom;
        if (pready_s2) begin
          rq_d2.push_back(d); rq_a2.push_back(a);
          valid_s2 = 1'b1; data_s2 = d; addr_s2 = a;
        end else if ($urandom_range(3, 0) == 0) begin
          ovf_exp[1] = 1'b1;
          valid_s2 = 1'b1; data_s2 = d; addr_s2 = a;
        end
      end
      step();
    end
    valid_s1 = 1'b0;
    valid_s2 = 1'b0;
    for (int i = 0; i < 2000 && !(pready_s1 && pready_s2 && grant == 2'b00); i++) step();
    repeat (3) step();
    chk("rnd_drain", {28'd0, pready_s2, pready_s1, grant}, 32'hC);
    rnd_mode = 1'b0;
    chk("rnd_err_ovf", 32'(err_ovf), 32'(ovf_exp));
    chk("rnd_err_tmo", 32'(err_tmo), 32'd0);
    chk("rnd_len", 32'(cap_b.size()), 32'(4 * (rq_d1.size() + rq_d2.size())));
    for (int i = 0; i + 3 < cap_g.size(); i += 4) begin
      chk($sformatf("rnd_word%0d_grp", i / 4), {30'd0, cap_g[i+1] ^ cap_g[i]} | {30'd0, cap_g[i+2] ^ cap_g[i]} |
          {30'd0, cap_g[i+3] ^ cap_g[i]}, 32'd0);
    end
    begin
      int j1, j2;
      j1 = 0; j2 = 0;
      for (int i = 0; i < cap_b.size(); i++) begin
        if (cap_g[i] == 2'b01 && j1 < 4 * rq_d1.size()) begin
          s0 = j1 / 4;
          chk($sformatf("rnd_c1_byte%0d", j1), 32'(cap_b[i]), 32'(rq_d1[s0][8*(j1%4) +: 8]));
          chk($sformatf("rnd_c1_addr%0d", j1), cap_a[i], rq_a1[s0]);
          j1++;
        end else if (cap_g[i] == 2'b10 && j2 < 4 * rq_d2.size()) begin
          s0 = j2 / 4;
          chk($sformatf("rnd_c2_byte%0d", j2), 32'(cap_b[i]), 32'(rq_d2[s0][8*(j2%4) +: 8]));
          chk($sformatf("rnd_c2_addr%0d", j2), cap_a[i], rq_a2[s0]);
          j2++;
        end else begin
          chk($sformatf("rnd_stray_byte%0d", i), {30'd0, cap_g[i]}, 32'hFFFF_FFFF);
        end
      end
      chk("rnd_c1_count", 32'(j1), 32'(4 * rq_d1.size()));
      chk("rnd_c2_count", 32'(j2), 32'(4 * rq_d2.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
